// File: rtl/conv3x3_sched.sv
// conv3x3_sched: loads a 3x3 kernel, slides a 3x3 window over a row-major pixel
// stream through two line buffers, and returns the external MAC result on a valid/ready stream.
module conv3x3_sched #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        w_valid,
    input  logic [17:0] w_data,
    output logic        w_ready,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [7:0]  mac_in0,
    output logic [7:0]  mac_in1,
    output logic [7:0]  mac_in2,
    output logic [7:0]  mac_in3,
    output logic [7:0]  mac_in4,
    output logic [7:0]  mac_in5,
    output logic [7:0]  mac_in6,
    output logic [7:0]  mac_in7,
    output logic [7:0]  mac_in8,
    output logic [17:0] mac_w0,
    output logic [17:0] mac_w1,
    output logic [17:0] mac_w2,
    output logic [17:0] mac_w3,
    output logic [17:0] mac_w4,
    output logic [17:0] mac_w5,
    output logic [17:0] mac_w6,
    output logic [17:0] mac_w7,
    output logic [17:0] mac_w8,
    input  logic [18:0] mac_result,
    output logic        out_valid,
    output logic [18:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);
    // state | meaning
    // IDLE  | waiting for start
    // LOADW | accepting the nine kernel weights
    // RUN   | accepting pixels, capturing one result per valid window
    // FLUSH | last pixel taken, final result waiting to be accepted

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOADW = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [17:0]     wt_q [9];
    logic [17:0]     wt_d [9];
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      lb0_q [WIDTH];
    logic [7:0]      lb0_d [WIDTH];
    logic [7:0]      lb1_q [WIDTH];
    logic [7:0]      lb1_d [WIDTH];
    // window columns, index 0 = top row
    logic [7:0]      win_l_q [3];
    logic [7:0]      win_l_d [3];
    logic [7:0]      win_m_q [3];
    logic [7:0]      win_m_d [3];
    logic            out_valid_q, out_valid_d;
    logic [18:0]     out_data_q, out_data_d;

    logic            w_hs;
    logic            pix_hs;
    logic            out_hs;
    logic            last_col;
    logic            last_row;
    logic            capture;
    logic [7:0]      rc_top;
    logic [7:0]      rc_mid;

    assign w_ready   = (state_q == S_LOADW);
    assign pix_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign busy      = (state_q != S_IDLE);
    assign w_hs      = w_valid && w_ready;
    assign pix_hs    = pix_valid && pix_ready;
    assign out_hs    = out_valid_q && out_ready;
    assign done      = (state_q == S_FLUSH) && out_hs;
    assign last_col  = (col_q == CW'(WIDTH - 1));
    assign last_row  = (row_q == RW'(HEIGHT - 1));
    assign capture   = pix_hs && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign rc_top    = lb1_q[col_q];
    assign rc_mid    = lb0_q[col_q];

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign mac_in0 = win_l_q[0];
    assign mac_in1 = win_m_q[0];
    assign mac_in2 = rc_top;
    assign mac_in3 = win_l_q[1];
    assign mac_in4 = win_m_q[1];
    assign mac_in5 = rc_mid;
    assign mac_in6 = win_l_q[2];
    assign mac_in7 = win_m_q[2];
    assign mac_in8 = pix_data;

    assign mac_w0 = wt_q[0];
    assign mac_w1 = wt_q[1];
    assign mac_w2 = wt_q[2];
    assign mac_w3 = wt_q[3];
    assign mac_w4 = wt_q[4];
    assign mac_w5 = wt_q[5];
    assign mac_w6 = wt_q[6];
    assign mac_w7 = wt_q[7];
    assign mac_w8 = wt_q[8];

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        wt_d        = wt_q;
        col_d       = col_q;
        row_d       = row_q;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        win_l_d     = win_l_q;
        win_m_d     = win_m_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOADW;
                    wcnt_d  = '0;
                end
            end
            S_LOADW: begin
                if (w_hs) begin
                    for (int k = 0; k < 9; k++) begin
                        if (wcnt_q == 4'(k)) wt_d[k] = w_data;
                    end
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd8) begin
                        state_d = S_RUN;
                        col_d   = '0;
                        row_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (pix_hs && last_col && last_row) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (out_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pix_hs) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            lb1_d[col_q] = lb0_q[col_q];
            lb0_d[col_q] = pix_data;
            // columns are refilled across a row wrap; stale columns never reach a capture
            win_l_d    = win_m_q;
            win_m_d[0] = rc_top;
            win_m_d[1] = rc_mid;
            win_m_d[2] = pix_data;
        end

        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = mac_result;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < 9; k++) wt_q[k] <= '0;
            for (int k = 0; k < 3; k++) begin
                win_l_q[k] <= '0;
                win_m_q[k] <= '0;
            end
            for (int k = 0; k < WIDTH; k++) begin
                lb0_q[k] <= '0;
                lb1_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wt_q        <= wt_d;
            win_l_q     <= win_l_d;
            win_m_q     <= win_m_d;
            lb0_q       <= lb0_d;
            lb1_q       <= lb1_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_sched.sv
// Bench for conv3x3_sched: four image sizes run side by side, each checked against a
// window-sum model of the image, with an abort-by-reset and ignored-input injection.
module tb_conv3x3_sched;
    localparam int NI = 4;
    localparam logic [31:0] SIZES = {8'd28, 8'd5, 8'd4, 8'd3};
    localparam logic [31:0] PCTS  = {8'd100, 8'd30, 8'd100, 8'd100};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_fin  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int W   = int'(SIZES[g*8 +: 8]);
        localparam int H   = W;
        localparam int PCT = int'(PCTS[g*8 +: 8]);

        logic        rst, start, w_valid, w_ready, pix_valid, pix_ready;
        logic        out_valid, out_ready, busy, done;
        logic [17:0] w_data;
        logic [7:0]  pix_data;
        logic [18:0] mac_result, out_data;
        logic [7:0]  mi [9];
        logic [17:0] mw [9];
        logic [31:0] acc;

        logic [17:0] wt [9];
        logic [7:0]  img [W*H];
        logic [18:0] exp_q [$];
        bit          mon_en = 1'b0;
        int          n_done, nready, bp;

        conv3x3_sched #(.WIDTH(W), .HEIGHT(H)) dut (
            .clk(clk), .rst(rst), .start(start),
            .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
            .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
            .mac_in0(mi[0]), .mac_in1(mi[1]), .mac_in2(mi[2]),
            .mac_in3(mi[3]), .mac_in4(mi[4]), .mac_in5(mi[5]),
            .mac_in6(mi[6]), .mac_in7(mi[7]), .mac_in8(mi[8]),
            .mac_w0(mw[0]), .mac_w1(mw[1]), .mac_w2(mw[2]),
            .mac_w3(mw[3]), .mac_w4(mw[4]), .mac_w5(mw[5]),
            .mac_w6(mw[6]), .mac_w7(mw[7]), .mac_w8(mw[8]),
            .mac_result(mac_result),
            .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
            .busy(busy), .done(done)
        );

        // external 9-tap MAC unit
        always_comb begin
            acc = '0;
            for (int k = 0; k < 9; k++) acc = acc + 32'(mi[k]) * 32'(mw[k]);
            mac_result = acc[18:0];
        end

        task automatic c(input string n, input longint a, input longint e);
            chk($sformatf("%0dx%0d %s", W, H, n), a, e);
        endtask

        function automatic logic [18:0] win_val(input int r, input int cc);
            logic [31:0] s = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s = s + 32'(img[(r - 2 + i) * W + (cc - 2 + j)]) * 32'(wt[3 * i + j]);
            return s[18:0];
        endfunction

        task automatic build_model();
            exp_q.delete();
            for (int r = 2; r < H; r++)
                for (int cc = 2; cc < W; cc++)
                    exp_q.push_back(win_val(r, cc));
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst = 1'b1; start = 1'b0; w_valid = 1'b0; pix_valid = 1'b0;
            pix_data = '0; out_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            c("rst busy", busy, 0);
            c("rst w_ready", w_ready, 0);
            c("rst pix_ready", pix_ready, 0);
            c("rst out_valid", out_valid, 0);
            c("rst done", done, 0);
            c("rst out_data", out_data, 0);
            for (int k = 0; k < 9; k++) begin
                c($sformatf("rst mac_w%0d", k), mw[k], 0);
                c($sformatf("rst mac_in%0d", k), mi[k], 0);
            end
        endtask

        task automatic load_weights();
            @(negedge clk);
            #1;
            c("idle w_ready", w_ready, 0);
            start = 1'b1; w_valid = 1'b1; w_data = 18'h3FFFF; pix_valid = 1'b0;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                start = 1'b0; w_valid = 1'b1; w_data = wt[k];
                pix_valid = 1'b1; pix_data = 8'hAA; out_ready = 1'b1;
                #1;
                c("loadw w_ready", w_ready, 1);
                c("loadw pix_ready", pix_ready, 0);
                c("loadw busy", busy, 1);
            end
            @(negedge clk);
            w_valid = 1'b0; pix_valid = 1'b0;
            #1;
            c("run pix_ready", pix_ready, 1);
            c("run w_ready", w_ready, 0);
            for (int k = 0; k < 9; k++) c($sformatf("mac_w%0d", k), mw[k], wt[k]);
        endtask

        task automatic run_image(input bit abort);
            int idx = 0;
            int budget = 0;
            bit pend = 1'b0;
            bit fin = 1'b0;
            bit inj;
            logic [18:0] pv = '0;
            nready = 0; bp = 0;
            while (!fin && budget < 20 * W * H + 100) begin
                @(negedge clk);
                budget++;
                out_ready = abort ? 1'b0 : ($urandom_range(99) < PCT);
                inj = !abort && (idx == (W * H) / 2);
                start = inj; w_valid = inj; w_data = 18'h2AAAA;
                pix_valid = (idx < W * H);
                pix_data  = (idx < W * H) ? img[idx] : 8'h00;
                #1;
                if (pend) begin
                    c("latency out_valid", out_valid, 1);
                    c("latency out_data", out_data, pv);
                    pend = 1'b0;
                end
                if (abort) begin
                    fin = out_valid;
                end else begin
                    if (out_valid && !out_ready) begin
                        c("backpressure pix_ready", pix_ready, 0);
                        if (idx < W * H) bp++;
                    end
                    if (idx < W * H && !pix_ready) nready++;
                    fin = out_valid && out_ready && done;
                end
                if (!fin && pix_valid && pix_ready) begin
                    if (idx / W >= 2 && idx % W >= 2) begin
                        pend = 1'b1;
                        pv = win_val(idx / W, idx % W);
                    end
                    idx++;
                end
            end
            start = 1'b0; w_valid = 1'b0; pix_valid = 1'b0;
            c(abort ? "abort reached out_valid" : "done reached", fin, 1);
            if (!abort) begin
                @(negedge clk);
                #1;
                c("busy after done", busy, 0);
                c("stall cycles match backpressure", nready, bp);
            end
        endtask

        always begin
            logic [18:0] e;
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (out_valid && out_ready) begin
                    c("result expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        c("out_data", out_data, e);
                        c("done on final", done, int'(exp_q.size() == 0));
                    end
                end else begin
                    c("done quiet", done, 0);
                end
                if (done) n_done++;
            end
        end

        initial begin
            rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_data = '0;
            pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
            case (g)
                0: begin
                    for (int k = 0; k < 9; k++) wt[k] = 18'd1;
                    for (int i = 0; i < W * H; i++) img[i] = 8'(i + 1);
                end
                1: begin
                    for (int k = 0; k < 9; k++) wt[k] = (k == 4) ? 18'd1 : 18'd0;
                    for (int i = 0; i < W * H; i++) img[i] = 8'(i);
                end
                default: begin
                    for (int k = 0; k < 9; k++) wt[k] = 18'($urandom_range(0, 18'h3FFFF));
                    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom_range(0, 255));
                end
            endcase
            build_model();
            case (g)
                0: begin
                    c("model count", exp_q.size(), 1);
                    c("model value", exp_q[0], 45);
                end
                1: begin
                    c("model count", exp_q.size(), 4);
                    c("model r0", exp_q[0], 5);
                    c("model r1", exp_q[1], 6);
                    c("model r2", exp_q[2], 9);
                    c("model r3", exp_q[3], 10);
                end
                default: c("model count", exp_q.size(), (W - 2) * (H - 2));
            endcase

            do_reset();
            load_weights();
            run_image(1'b1);
            do_reset();

            n_done = 0;
            mon_en = 1'b1;
            load_weights();
            run_image(1'b0);
            mon_en = 1'b0;
            c("results left over", exp_q.size(), 0);
            c("done pulses", n_done, 1);
            for (int k = 0; k < 9; k++) c($sformatf("weights held w%0d", k), mw[k], wt[k]);
            n_fin++;
        end
    end

    initial begin
        for (int t = 0; t < 30000 && n_fin < NI; t++) @(negedge clk);
        chk("all configurations finished", n_fin, NI);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
